// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the memory-subsystem master and slave.
//   slave_state_t      : slave protocol FSM states
//   I2C_ACK / I2C_NACK : SDA level of the acknowledge bit
//   CLK_FREQ_HZ / SCL_FREQ_HZ : default system clock and bus rate
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdByte,
    StRdAck,
    StWaitStop
  } slave_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int unsigned CLK_FREQ_HZ = 50_000_000;
  localparam int unsigned SCL_FREQ_HZ = 100_000;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the clk domain and produces single-cycle bus events.
//   clk_i, rst_i             : system clock, synchronous active-high reset
//   scl_i, sda_i             : raw bus pins
//   sda_o                    : synchronized SDA level
//   scl_rise_o, scl_fall_o   : SCL edge pulses
//   start_o, stop_o          : START (SDA fall, SCL high) / STOP (SDA rise, SCL high) pulses
// Pin-to-event latency is SYNC_STAGES + 1 clocks at the consumer's flops.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
  end

  // Reset to the idle-bus level so no spurious events follow reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SCL must be high on both samples so an SCL edge is never mistaken for START/STOP.
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C slave with a MEM_DEPTH-byte register file behind an auto-incrementing word pointer.
//   clk, rst        : system clock, synchronous active-high reset (clears memory and pointer)
//   scl             : bus clock from master (never stretched)
//   sda             : open-drain data, driven 0 or released
//   busy            : high from address match until STOP / repeated START
//   wr_strobe/addr/data : one-clock report of each byte committed to memory
//   start_det, stop_det : one-clock START / STOP pulses
// The first write byte after the address loads the pointer; later bytes are stored.
module i2c_mem_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned MEM_DEPTH   = 16,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned AW = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  inout  wire           sda,
  output logic          busy,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          start_det,
  output logic          stop_det
);

  logic sda_s, scl_rise, scl_fall, start_ev, stop_ev;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i     (clk),
    .rst_i     (rst),
    .scl_i     (scl),
    .sda_i     (sda),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_ev),
    .stop_o    (stop_ev)
  );

  slave_state_t  state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d, shift_in;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          sda_low_q, sda_low_d;  // 1 = pull SDA low
  logic          busy_q, busy_d;
  logic          rw_q, rw_d;
  logic          first_q, first_d;      // next write byte is the pointer
  logic          ack_drv_q, ack_drv_d;  // ACK bit currently being driven
  logic          ld_q, ld_d;            // load next read byte on coming SCL fall
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    mem_q [MEM_DEPTH];
  logic [7:0]    rd_byte;

  assign rd_byte  = mem_q[ptr_q];
  assign shift_in = {shift_q[6:0], sda_s};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_low_d   = sda_low_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    first_d     = first_q;
    ack_drv_d   = ack_drv_q;
    ld_d        = ld_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (start_ev || stop_ev) begin
      // Any partial byte is dropped; the bus is released immediately.
      state_d   = start_ev ? StAddr : StIdle;
      cnt_d     = 3'd0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
      ack_drv_d = 1'b0;
      ld_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shift_in[7:1] == SLAVE_ADDR) begin
                busy_d    = 1'b1;
                rw_d      = shift_in[0];
                ack_drv_d = 1'b0;
                state_d   = StAddrAck;
              end else begin
                state_d = StWaitStop;
              end
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_low_d = 1'b1;
              ack_drv_d = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              if (rw_q) begin
                sda_low_d = ~rd_byte[7];
                shift_d   = {rd_byte[6:0], 1'b0};
                cnt_d     = 3'd1;
                state_d   = StRdByte;
              end else begin
                sda_low_d = 1'b0;
                first_d   = 1'b1;
                cnt_d     = 3'd0;
                state_d   = StWrByte;
              end
            end
          end
        end
        StWrByte: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (first_q) begin
                ptr_d   = shift_in[AW-1:0];
                first_d = 1'b0;
              end else begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = shift_in;
                ptr_d       = ptr_q + 1'b1;
              end
              ack_drv_d = 1'b0;
              state_d   = StWrAck;
            end
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_low_d = 1'b1;
              ack_drv_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              ack_drv_d = 1'b0;
              state_d   = StWrByte;
            end
          end
        end
        StRdByte: begin
          if (scl_fall) begin
            if (ld_q) begin
              sda_low_d = ~rd_byte[7];
              shift_d   = {rd_byte[6:0], 1'b0};
              cnt_d     = 3'd1;
              ld_d      = 1'b0;
            end else if (cnt_q == 3'd0) begin
              // All eight bits presented; let the master drive its ACK.
              sda_low_d = 1'b0;
              ptr_d     = ptr_q + 1'b1;
              state_d   = StRdAck;
            end else begin
              sda_low_d = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              cnt_d     = cnt_q + 3'd1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              ld_d    = 1'b1;
              state_d = StRdByte;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        StWaitStop: sda_low_d = 1'b0;
        default:    state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      sda_low_q   <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      first_q     <= 1'b0;
      ack_drv_q   <= 1'b0;
      ld_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_low_q   <= sda_low_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      ack_drv_q   <= ack_drv_d;
      ld_q        <= ld_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      if (wr_strobe_d) mem_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign sda       = sda_low_q ? 1'b0 : 1'bz;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign start_det = start_ev;
  assign stop_det  = stop_ev;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Directed bench: bus-master tasks bit-bang SCL/SDA against a pulled-up SDA line.
// SCL runs at 100 clocks per bit (QCLK clocks per quarter) to keep run time short.
module tb_i2c_mem_slave;

  localparam int unsigned QCLK = 25;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_sda_low;
  wire        sda_bus;
  logic       busy, wr_strobe, start_det, stop_det;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor tallies, only written here; tests compare deltas.
  int          n_start = 0, n_stop = 0, n_strb = 0, busy_cnt = 0, dut_low_cnt = 0;
  logic [11:0] strb_log [64];

  always #10 clk = ~clk;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  i2c_mem_slave dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda_bus),
    .busy     (busy),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  always @(negedge clk) begin
    if (wr_strobe) begin
      strb_log[n_strb % 64] <= {wr_addr, wr_data};
      n_strb <= n_strb + 1;
    end
    if (start_det) n_start <= n_start + 1;
    if (stop_det) n_stop <= n_stop + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (!m_sda_low && sda_bus === 1'b0) dut_low_cnt <= dut_low_cnt + 1;
  end

  task automatic wait_q();
    repeat (QCLK) @(negedge clk);
  endtask

  task automatic bit_w(input logic b);
    m_sda_low = ~b;
    wait_q();
    scl = 1'b1;
    wait_q();
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic bit_r(output logic v);
    m_sda_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    v = sda_bus;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic byte_w(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_w(d[i]);
    bit_r(ack);
  endtask

  task automatic byte_r(input logic ack_in, output logic [7:0] d);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      bit_r(v);
      d[i] = v;
    end
    bit_w(ack_in);
  endtask

  // Works from idle (SCL high) and as a repeated START (SCL low).
  task automatic i2c_start();
    m_sda_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    m_sda_low = 1'b1;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    m_sda_low = 1'b0;
    wait_q();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    scl = 1'b1;
    m_sda_low = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, wr_strobe, start_det, stop_det} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {busy, wr_strobe, start_det, stop_det});
    else n_pass++;
    n_checks++;
    if (wr_addr !== 4'h0) $display("FAIL reset_wr_addr: got %h want 0", wr_addr);
    else n_pass++;
    n_checks++;
    if (wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", wr_data);
    else n_pass++;
    n_checks++;
    if (sda_bus !== 1'b1) $display("FAIL reset_sda: got %b want 1", sda_bus);
    else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic [3:0] a;
    int s0, p0;
    s0 = n_strb;
    p0 = n_stop;
    i2c_start();
    byte_w(8'hA0, a[3]);
    byte_w(8'h03, a[2]);
    byte_w(8'hA5, a[1]);
    byte_w(8'h5A, a[0]);
    n_checks++;
    if (a !== 4'b0000) $display("FAIL wr_acks: got %b want 0000", a);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL wr_busy_before_stop: got %b want 1", busy);
    else n_pass++;
    i2c_stop();
    wait_q();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL wr_busy_after_stop: got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (n_stop - p0 !== 1) $display("FAIL wr_stop_det: got %0d want 1", n_stop - p0);
    else n_pass++;
    n_checks++;
    if (n_strb - s0 !== 2) $display("FAIL wr_strobe_count: got %0d want 2", n_strb - s0);
    else n_pass++;
    n_checks++;
    if (strb_log[s0 % 64] !== 12'h3A5)
      $display("FAIL wr_strobe0: got %h want 3a5", strb_log[s0 % 64]);
    else n_pass++;
    n_checks++;
    if (strb_log[(s0 + 1) % 64] !== 12'h45A)
      $display("FAIL wr_strobe1: got %h want 45a", strb_log[(s0 + 1) % 64]);
    else n_pass++;
  endtask

  task automatic test_read_restart();
    logic [2:0] a;
    logic [7:0] d0, d1;
    int s0, t0;
    s0 = n_strb;
    t0 = n_start;
    i2c_start();
    byte_w(8'hA0, a[2]);
    byte_w(8'h03, a[1]);
    i2c_start();
    byte_w(8'hA1, a[0]);
    byte_r(1'b0, d0);
    byte_r(1'b1, d1);
    i2c_stop();
    wait_q();
    n_checks++;
    if (a !== 3'b000) $display("FAIL rd_acks: got %b want 000", a);
    else n_pass++;
    n_checks++;
    if (d0 !== 8'hA5) $display("FAIL rd_byte0: got %h want a5", d0);
    else n_pass++;
    n_checks++;
    if (d1 !== 8'h5A) $display("FAIL rd_byte1: got %h want 5a", d1);
    else n_pass++;
    n_checks++;
    if (n_start - t0 !== 2) $display("FAIL rd_start_det: got %0d want 2", n_start - t0);
    else n_pass++;
    n_checks++;
    if (n_strb - s0 !== 0) $display("FAIL rd_no_strobe: got %0d want 0", n_strb - s0);
    else n_pass++;
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    int s0, b0, l0;
    s0 = n_strb;
    b0 = busy_cnt;
    l0 = dut_low_cnt;
    i2c_start();
    byte_w(8'hA2, a0);
    byte_w(8'h77, a1);
    i2c_stop();
    wait_q();
    n_checks++;
    if ({a0, a1} !== 2'b11) $display("FAIL na_acks: got %b want 11", {a0, a1});
    else n_pass++;
    n_checks++;
    if (dut_low_cnt - l0 !== 0) $display("FAIL na_sda_driven: got %0d want 0", dut_low_cnt - l0);
    else n_pass++;
    n_checks++;
    if (busy_cnt - b0 !== 0) $display("FAIL na_busy: got %0d want 0", busy_cnt - b0);
    else n_pass++;
    n_checks++;
    if (n_strb - s0 !== 0) $display("FAIL na_no_strobe: got %0d want 0", n_strb - s0);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [6:0] a;
    logic [7:0] d0, d1;
    int s0;
    s0 = n_strb;
    i2c_start();
    byte_w(8'hA0, a[6]);
    byte_w(8'h0F, a[5]);
    byte_w(8'h11, a[4]);
    byte_w(8'h22, a[3]);
    i2c_stop();
    i2c_start();
    byte_w(8'hA0, a[2]);
    byte_w(8'h0F, a[1]);
    i2c_start();
    byte_w(8'hA1, a[0]);
    byte_r(1'b0, d0);
    byte_r(1'b1, d1);
    i2c_stop();
    n_checks++;
    if (a !== 7'b0) $display("FAIL wrap_acks: got %b want 0000000", a);
    else n_pass++;
    n_checks++;
    if (n_strb - s0 !== 2 || strb_log[s0 % 64] !== 12'hF11 || strb_log[(s0 + 1) % 64] !== 12'h022)
      $display("FAIL wrap_strobes: got %0d %h %h want 2 f11 022", n_strb - s0,
               strb_log[s0 % 64], strb_log[(s0 + 1) % 64]);
    else n_pass++;
    n_checks++;
    if ({d0, d1} !== 16'h1122) $display("FAIL wrap_read: got %h want 1122", {d0, d1});
    else n_pass++;
  endtask

  task automatic test_partial_stop();
    logic [3:0] a;
    logic [7:0] d;
    int s0;
    s0 = n_strb;
    i2c_start();
    byte_w(8'hA0, a[3]);
    byte_w(8'h02, a[2]);
    bit_w(1'b1);
    bit_w(1'b0);
    bit_w(1'b1);
    bit_w(1'b0);
    i2c_stop();
    wait_q();
    n_checks++;
    if (n_strb - s0 !== 0) $display("FAIL part_no_strobe: got %0d want 0", n_strb - s0);
    else n_pass++;
    n_checks++;
    if ({busy, sda_bus} !== 2'b01) $display("FAIL part_idle: got %b want 01", {busy, sda_bus});
    else n_pass++;
    i2c_start();
    byte_w(8'hA0, a[1]);
    byte_w(8'h07, a[0]);
    i2c_start();
    byte_w(8'hA0, a[3]);
    byte_w(8'h3C, a[2]);
    i2c_stop();
    n_checks++;
    if (a !== 4'b0000) $display("FAIL part_next_acks: got %b want 0000", a);
    else n_pass++;
    n_checks++;
    // Pointer byte 0x07 then after the restart 0x3C is itself a pointer byte: no write.
    if (n_strb - s0 !== 0) $display("FAIL part_ptr_only: got %0d want 0", n_strb - s0);
    else n_pass++;
    i2c_start();
    byte_w(8'hA0, a[1]);
    byte_w(8'h07, a[0]);
    byte_w(8'h3C, a[3]);
    i2c_stop();
    i2c_start();
    byte_w(8'hA0, a[2]);
    byte_w(8'h07, a[1]);
    i2c_start();
    byte_w(8'hA1, a[0]);
    byte_r(1'b1, d);
    i2c_stop();
    n_checks++;
    if (a !== 4'b0000 || n_strb - s0 !== 1 || strb_log[s0 % 64] !== 12'h73C)
      $display("FAIL part_next_write: got acks %b n %0d %h want 0000 1 73c", a, n_strb - s0,
               strb_log[s0 % 64]);
    else n_pass++;
    n_checks++;
    if (d !== 8'h3C) $display("FAIL part_readback: got %h want 3c", d);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    logic [5:0] a;
    logic [7:0] d;
    i2c_start();
    byte_w(8'hA0, a[5]);
    byte_w(8'h04, a[4]);
    i2c_start();
    byte_w(8'hA1, a[3]);
    // mem[4] = 5A: bit7 = 0, so the slave is now pulling SDA low.
    n_checks++;
    if (sda_bus !== 1'b0) $display("FAIL rst_pre_drive: got %b want 0", sda_bus);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (sda_bus !== 1'b1) $display("FAIL rst_sda_release: got %b want 1", sda_bus);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    scl = 1'b1;
    wait_q();
    wait_q();
    i2c_start();
    byte_w(8'hA0, a[2]);
    byte_w(8'h04, a[1]);
    i2c_start();
    byte_w(8'hA1, a[0]);
    byte_r(1'b1, d);
    i2c_stop();
    n_checks++;
    if (a[2:0] !== 3'b000) $display("FAIL rst_after_acks: got %b want 000", a[2:0]);
    else n_pass++;
    n_checks++;
    if (d !== 8'h00) $display("FAIL rst_mem_cleared: got %h want 00", d);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_restart();
    test_wrong_addr();
    test_wrap();
    test_partial_stop();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
